// File: rtl/cic_rate_ctrl.sv
// ---------------------------------------------------------------------------
// cic_rate_ctrl
//
// Run-time decimation-rate sequencer for a variable-rate CIC decimator.
// Rate requests arrive on a small AXI-stream config port and are range
// checked. A legal new rate is held until the decimator has just emitted an
// output sample, when its phase counter has restarted and a reload is safe.
// If no output sample arrives within ALIGN_TIMEOUT clocks, the new rate is
// applied anyway. After the rate load, the next FLUSH_OUTPUTS filter outputs
// carry the settling transient and are blanked before the output stream
// resumes.
//
// Optional feature: define CIC_RATE_CTRL_STATS_EN to add two saturating
// 16-bit statistics counters, rate_change_cnt and cfg_err_cnt.
//
// Ports:
//   clk                 clock
//   reset_n             synchronous active-low reset
//   s_axis_cfg_tdata    requested decimation ratio (unsigned)
//   s_axis_cfg_tvalid   request valid
//   s_axis_cfg_tready   request accepted when high (IDLE only)
//   m_axis_rate_tdata   rate word to the filter
//   m_axis_rate_tvalid  single-cycle rate-load strobe to the filter
//   cic_out_tdata       filter output data
//   cic_out_tvalid      filter output valid
//   m_axis_out_tdata    registered output data (holds between samples)
//   m_axis_out_tvalid   registered output valid, blanked while settling
//   current_rate        last applied ratio
//   busy                reconfiguration in progress
//   cfg_err             one-cycle pulse when a request is rejected
//   rate_change_cnt     (stats only) number of rate loads, saturating
//   cfg_err_cnt         (stats only) number of rejected requests, saturating
// ---------------------------------------------------------------------------
module cic_rate_ctrl #(
    parameter int RATE_DW       = 32,
    parameter int OUT_DW        = 32,
    parameter int CIC_R_MAX     = 10,
    parameter int CIC_R_MIN     = 2,
    parameter int FLUSH_OUTPUTS = 7,
    parameter int ALIGN_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
    input  logic               s_axis_cfg_tvalid,
    output logic               s_axis_cfg_tready,
    output logic [RATE_DW-1:0] m_axis_rate_tdata,
    output logic               m_axis_rate_tvalid,
    input  logic [OUT_DW-1:0]  cic_out_tdata,
    input  logic               cic_out_tvalid,
    output logic [OUT_DW-1:0]  m_axis_out_tdata,
    output logic               m_axis_out_tvalid,
    output logic [RATE_DW-1:0] current_rate,
    output logic               busy,
`ifdef CIC_RATE_CTRL_STATS_EN
    output logic [15:0]        rate_change_cnt,
    output logic [15:0]        cfg_err_cnt,
`endif
    output logic               cfg_err
);

    // Counter widths: one spare bit above what the terminal value needs, so
    // the counters can never wrap before the == compare fires.
    localparam int TO_W = $clog2((ALIGN_TIMEOUT > 2) ? ALIGN_TIMEOUT : 2) + 1;
    localparam int FL_W = $clog2((FLUSH_OUTPUTS > 2) ? FLUSH_OUTPUTS : 2) + 1;

    localparam logic [RATE_DW-1:0] R_MAX   = RATE_DW'(CIC_R_MAX);
    localparam logic [RATE_DW-1:0] R_MIN   = RATE_DW'(CIC_R_MIN);
    // Timeout fires on the ALIGN_TIMEOUT-th clock spent in ALIGN.
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(ALIGN_TIMEOUT - 1);
    localparam logic [FL_W-1:0]    FL_TERM = FL_W'(FLUSH_OUTPUTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        APPLY = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t             state_reg;
    logic [TO_W-1:0]    timeout_cnt_reg;
    logic [FL_W-1:0]    flush_cnt_reg;
    logic [RATE_DW-1:0] pend_rate_reg;
    logic [RATE_DW-1:0] current_rate_reg;
    logic [RATE_DW-1:0] rate_tdata_reg;
    logic               rate_tvalid_reg;
    logic               tready_reg;
    logic               busy_reg;
    logic               cfg_err_reg;
    logic [OUT_DW-1:0]  out_tdata_reg;
    logic               out_tvalid_reg;
`ifdef CIC_RATE_CTRL_STATS_EN
    logic [15:0]        rate_change_cnt_reg;
    logic [15:0]        cfg_err_cnt_reg;
`endif

    // tready_reg is only ever high in IDLE, so a handshake implies IDLE.
    logic            cfg_fire;
    logic            req_out_of_range;
    logic            req_same;
    logic            timeout_hit;
    logic [FL_W-1:0] flush_cnt_next;
    logic            suppress;

    always_comb begin
        cfg_fire         = s_axis_cfg_tvalid && tready_reg;
        req_out_of_range = (s_axis_cfg_tdata < R_MIN) || (s_axis_cfg_tdata > R_MAX);
        req_same         = (s_axis_cfg_tdata == current_rate_reg);
        timeout_hit      = (timeout_cnt_reg == TO_LAST);
        flush_cnt_next   = flush_cnt_reg + 1'b1;
        // The rate-load cycle and the flush window carry settling samples.
        suppress         = (state_reg == APPLY) || (state_reg == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            timeout_cnt_reg  <= '0;
            flush_cnt_reg    <= '0;
            pend_rate_reg    <= R_MAX;
            current_rate_reg <= R_MAX;
            rate_tdata_reg   <= R_MAX;
            rate_tvalid_reg  <= 1'b0;
            tready_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            cfg_err_reg      <= 1'b0;
            out_tdata_reg    <= '0;
            out_tvalid_reg   <= 1'b0;
`ifdef CIC_RATE_CTRL_STATS_EN
            rate_change_cnt_reg <= '0;
            cfg_err_cnt_reg     <= '0;
`endif
        end else begin
            cfg_err_reg     <= 1'b0;
            rate_tvalid_reg <= 1'b0;

            // Output stage: data captured on every valid sample, valid
            // gated while the filter is settling.
            if (cic_out_tvalid) begin
                out_tdata_reg <= cic_out_tdata;
            end
            out_tvalid_reg <= cic_out_tvalid && !suppress;

            case (state_reg)
                IDLE: begin
                    tready_reg <= 1'b1;
                    if (cfg_fire) begin
                        if (req_out_of_range) begin
                            cfg_err_reg <= 1'b1;
                        end else if (!req_same) begin
                            pend_rate_reg   <= s_axis_cfg_tdata;
                            timeout_cnt_reg <= '0;
                            state_reg       <= ALIGN;
                            busy_reg        <= 1'b1;
                            tready_reg      <= 1'b0;
                        end
                    end
                end

                ALIGN: begin
                    // An output sample means the downsampler phase has just
                    // restarted. That boundary sample was produced at the
                    // old rate and is passed by the output stage.
                    if (cic_out_tvalid || timeout_hit) begin
                        state_reg       <= APPLY;
                        rate_tvalid_reg <= 1'b1;
                        rate_tdata_reg  <= pend_rate_reg;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end

                APPLY: begin
                    current_rate_reg <= pend_rate_reg;
                    flush_cnt_reg    <= '0;
                    if (FLUSH_OUTPUTS == 0) begin
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                        tready_reg <= 1'b1;
                    end else begin
                        state_reg <= FLUSH;
                    end
                end

                FLUSH: begin
                    if (cic_out_tvalid) begin
                        flush_cnt_reg <= flush_cnt_next;
                        if (flush_cnt_next == FL_TERM) begin
                            state_reg  <= IDLE;
                            busy_reg   <= 1'b0;
                            tready_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    tready_reg <= 1'b0;
                end
            endcase

`ifdef CIC_RATE_CTRL_STATS_EN
            if ((state_reg == APPLY) && (rate_change_cnt_reg != 16'hFFFF)) begin
                rate_change_cnt_reg <= rate_change_cnt_reg + 16'd1;
            end
            if (cfg_err_reg && (cfg_err_cnt_reg != 16'hFFFF)) begin
                cfg_err_cnt_reg <= cfg_err_cnt_reg + 16'd1;
            end
`endif
        end
    end

    assign s_axis_cfg_tready  = tready_reg;
    assign m_axis_rate_tdata  = rate_tdata_reg;
    assign m_axis_rate_tvalid = rate_tvalid_reg;
    assign m_axis_out_tdata   = out_tdata_reg;
    assign m_axis_out_tvalid  = out_tvalid_reg;
    assign current_rate       = current_rate_reg;
    assign busy               = busy_reg;
    assign cfg_err            = cfg_err_reg;
`ifdef CIC_RATE_CTRL_STATS_EN
    assign rate_change_cnt    = rate_change_cnt_reg;
    assign cfg_err_cnt        = cfg_err_cnt_reg;
`endif

endmodule
